// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding control block: operand mux
// selects, controller state codes and default widths.
package hazard_pkg;

    // Default register-address and stall-counter widths
    localparam int LEN_REG_DEFAULT = 5;
    localparam int LEN_CNT_DEFAULT = 32;

    // EX operand 3:1 mux select; bit 1 has priority in the mux
    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_REGFILE = 2'b00;  // value read from ID/EX
    localparam fwd_sel_t FWD_MEMWB   = 2'b01;  // result in MEM/WB
    localparam fwd_sel_t FWD_EXMEM   = 2'b10;  // result in EX/MEM

    // Controller state encodings
    typedef logic [1:0] hz_state_t;
    localparam hz_state_t ST_RUN        = 2'b00;
    localparam hz_state_t ST_LOAD_STALL = 2'b01;
    localparam hz_state_t ST_MEM_WAIT   = 2'b10;

endpackage : hazard_pkg

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-operand forwarding decision: compares one ID source register against
// the EX and MEM destinations and returns the next EX mux select.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int LEN_REG = LEN_REG_DEFAULT
) (
    input  logic [LEN_REG-1:0] i_src,
    input  logic               i_uses,
    input  logic [LEN_REG-1:0] i_ex_rd,
    input  logic               i_ex_reg_write,
    input  logic [LEN_REG-1:0] i_mem_rd,
    input  logic               i_mem_reg_write,
    output fwd_sel_t           o_sel
);

    logic w_src_live;
    logic w_ex_hit;
    logic w_mem_hit;

    // Register 0 is hardwired to zero, so it is never a forwarding target
    assign w_src_live = i_uses && (i_src != '0);
    assign w_ex_hit   = w_src_live && i_ex_reg_write  && (i_ex_rd  == i_src);
    assign w_mem_hit  = w_src_live && i_mem_reg_write && (i_mem_rd == i_src);

    // Youngest producer wins: EX/MEM result before MEM/WB result
    always_comb begin
        // NOTE: o_sel is assigned on every path through this block, so no latch is inferred.
        o_sel = FWD_REGFILE;
        if (w_ex_hit) begin
            o_sel = FWD_EXMEM;
        end else if (w_mem_hit) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule : fwd_select

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding control for the 5-stage pipeline: load-use stall,
// taken-branch squash, data-memory freeze, registered EX operand selects and
// a saturating stall-cycle counter.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int LEN_REG = LEN_REG_DEFAULT,
    parameter int LEN_CNT = LEN_CNT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEN_REG-1:0] i_id_rs,
    input  logic [LEN_REG-1:0] i_id_rt,
    input  logic               i_id_uses_rs,
    input  logic               i_id_uses_rt,
    input  logic [LEN_REG-1:0] i_ex_rd,
    input  logic               i_ex_reg_write,
    input  logic               i_ex_mem_read,
    input  logic [LEN_REG-1:0] i_mem_rd,
    input  logic               i_mem_reg_write,
    input  logic               i_ex_branch_taken,
    input  logic               i_mem_busy,
    output logic               o_pipe_hold,
    output logic               o_ifid_hold,
    output logic               o_idex_bubble,
    output logic               o_ifid_flush,
    output fwd_sel_t           o_fwd_a_sel,
    output fwd_sel_t           o_fwd_b_sel,
    output logic [LEN_CNT-1:0] o_stall_cycles
);

    hz_state_t          r_state;
    hz_state_t          w_next_state;
    fwd_sel_t           r_fwd_a_sel;
    fwd_sel_t           r_fwd_b_sel;
    fwd_sel_t           w_next_a_sel;
    fwd_sel_t           w_next_b_sel;
    logic [LEN_CNT-1:0] r_stall_cycles;

    logic w_load_use;
    logic w_pipe_hold;
    logic w_ifid_hold;
    logic w_idex_bubble;
    logic w_ifid_flush;
    logic w_stall_event;
    logic w_cnt_full;

    // Next select for each operand, captured into the EX-stage registers
    fwd_select #(.LEN_REG(LEN_REG)) u_fwd_a (
        .i_src           (i_id_rs),
        .i_uses          (i_id_uses_rs),
        .i_ex_rd         (i_ex_rd),
        .i_ex_reg_write  (i_ex_reg_write),
        .i_mem_rd        (i_mem_rd),
        .i_mem_reg_write (i_mem_reg_write),
        .o_sel           (w_next_a_sel)
    );

    fwd_select #(.LEN_REG(LEN_REG)) u_fwd_b (
        .i_src           (i_id_rt),
        .i_uses          (i_id_uses_rt),
        .i_ex_rd         (i_ex_rd),
        .i_ex_reg_write  (i_ex_reg_write),
        .i_mem_rd        (i_mem_rd),
        .i_mem_reg_write (i_mem_reg_write),
        .o_sel           (w_next_b_sel)
    );

    // A load in EX whose destination is read by the instruction in ID
    assign w_load_use = i_ex_mem_read && i_ex_reg_write && (i_ex_rd != '0) &&
                        ((i_id_uses_rs && (i_ex_rd == i_id_rs)) ||
                         (i_id_uses_rt && (i_ex_rd == i_id_rt)));

    // Control decode and next state; reset > mem_busy > branch > load-use
    always_comb begin
        w_pipe_hold   = 1'b0;
        w_ifid_hold   = 1'b0;
        w_idex_bubble = 1'b0;
        w_ifid_flush  = 1'b0;
        w_next_state  = r_state;
        if (reset) begin
            w_next_state = ST_RUN;
        end else if (i_mem_busy) begin
            w_pipe_hold  = 1'b1;
            w_next_state = ST_MEM_WAIT;
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_next_state = ST_RUN;
                    if (i_ex_branch_taken) begin
                        w_ifid_flush  = 1'b1;
                        w_idex_bubble = 1'b1;
                    end else if (w_load_use) begin
                        w_ifid_hold   = 1'b1;
                        w_idex_bubble = 1'b1;
                        w_next_state  = ST_LOAD_STALL;
                    end
                end
                ST_LOAD_STALL: begin
                    // The bubble is already in EX, so load-use is not re-checked
                    w_next_state = ST_RUN;
                    if (i_ex_branch_taken) begin
                        w_ifid_flush  = 1'b1;
                        w_idex_bubble = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    w_next_state = ST_RUN;
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    // Controller state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // EX operand selects: frozen during pipe_hold, cleared for an injected bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fwd_a_sel <= FWD_REGFILE;
            r_fwd_b_sel <= FWD_REGFILE;
        end else if (!w_pipe_hold) begin
            if (w_idex_bubble) begin
                r_fwd_a_sel <= FWD_REGFILE;
                r_fwd_b_sel <= FWD_REGFILE;
            end else begin
                r_fwd_a_sel <= w_next_a_sel;
                r_fwd_b_sel <= w_next_b_sel;
            end
        end
    end

    assign w_stall_event = w_pipe_hold || w_ifid_hold;
    assign w_cnt_full    = &r_stall_cycles;

    // Stall-cycle counter, saturating at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall_event && !w_cnt_full) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign o_pipe_hold    = w_pipe_hold;
    assign o_ifid_hold    = w_ifid_hold;
    assign o_idex_bubble  = w_idex_bubble;
    assign o_ifid_flush   = w_ifid_flush;
    assign o_fwd_a_sel    = r_fwd_a_sel;
    assign o_fwd_b_sel    = r_fwd_b_sel;
    assign o_stall_cycles = r_stall_cycles;

endmodule : hazard_forward_unit
